// File: rtl/btn_pkg.sv
// btn_pkg: shared channel state type and 100 MHz timing defaults for the button bank.
package btn_pkg;
    typedef enum logic [1:0] {RELEASED, PRESSED, HELD} btn_state_t;
    localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/btn_debounce_bank_if.sv
// btn_debounce_bank_if: raw button pins in, debounced levels and event pulses out.
interface btn_debounce_bank_if #(
    parameter int unsigned N_CH = 6
);
    logic [N_CH-1:0] btn_i;
    logic [N_CH-1:0] btn_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] long_o;
    logic [N_CH-1:0] repeat_o;
    modport master (output btn_i, input btn_o, press_o, release_o, long_o, repeat_o);
    modport slave  (input btn_i, output btn_o, press_o, release_o, long_o, repeat_o);
endinterface

// File: rtl/btn_channel.sv
// btn_channel: one button - 2-FF sync, stability filter and RELEASED/PRESSED/HELD event FSM.
// Auto-repeat in HELD exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          ACT_LOW       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HW = $clog2(max2(LONG_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [SW-1:0] STAB_M1 = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_M1 = HW'(LONG_CYCLES - 1);
    logic sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [HW-1:0] hold_q, hold_d;
    btn_state_t st_q, st_d;
    logic btn_q, btn_d, press_q, press_d, release_q, release_d, long_q, long_d;
    logic diff, flip, rise, fall;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [HW-1:0] REP_M1 = HW'(REPEAT_CYCLES - 1);
    logic repeat_q, repeat_d;
`endif
    always_comb begin
        sync1_d   = btn_i ^ ACT_LOW;
        sync2_d   = sync1_q;
        diff      = sync2_q != btn_q;
        flip      = diff && (stab_q == STAB_M1);
        stab_d    = (diff && !flip) ? stab_q + 1'b1 : '0;
        btn_d     = btn_q ^ flip;
        rise      = flip && !btn_q;
        fall      = flip && btn_q;
        press_d   = rise;
        release_d = fall;
        long_d    = 1'b0;
        st_d      = st_q;
        hold_d    = hold_q;
`ifdef BTN_AUTOREPEAT_EN
        repeat_d  = 1'b0;
`endif
        // a fall always beats a long/repeat threshold in the same cycle
        case (st_q)
            RELEASED: if (rise) begin
                hold_d = '0;
                st_d   = PRESSED;
            end
            PRESSED: if (fall) st_d = RELEASED;
                else if (hold_q == LONG_M1) begin
                    long_d = 1'b1;
                    hold_d = '0;
                    st_d   = HELD;
                end else hold_d = hold_q + 1'b1;
            HELD: if (fall) st_d = RELEASED;
`ifdef BTN_AUTOREPEAT_EN
                else if (hold_q == REP_M1) begin
                    repeat_d = 1'b1;
                    hold_d   = '0;
                end else hold_d = hold_q + 1'b1;
`endif
            default: st_d = RELEASED;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stab_q    <= '0;
            hold_q    <= '0;
            st_q      <= RELEASED;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            st_q      <= st_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
`ifdef BTN_AUTOREPEAT_EN
            repeat_q  <= repeat_d;
`endif
        end
    end
    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
`ifdef BTN_AUTOREPEAT_EN
    assign repeat_o  = repeat_q;
`else
    assign repeat_o  = 1'b0;
`endif
endmodule

// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: N_CH independent debounced button channels with press/release/long/repeat pulses.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise repeat_o stays low.
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int unsigned     N_CH          = 6,
    parameter int unsigned     STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned     LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned     REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter logic [N_CH-1:0] ACT_LOW_MASK  = N_CH'(1)
) (
    input logic                clk_i,
    input logic                rst_i,
    btn_debounce_bank_if.slave bus
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACT_LOW      (ACT_LOW_MASK[i])
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .btn_i    (bus.btn_i[i]),
            .btn_o    (bus.btn_o[i]),
            .press_o  (bus.press_o[i]),
            .release_o(bus.release_o[i]),
            .long_o   (bus.long_o[i]),
            .repeat_o (bus.repeat_o[i])
        );
    end
endmodule
